// File: rtl/p_signal_sequencer_if.sv
// Avalon-MM slave bus bundle for the signal sequencer register file.
interface p_signal_sequencer_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/p_signal_sequencer.sv
// Timed lock/alarm output sequencer (IDLE -> ACTIVE -> HOLDOFF) behind an Avalon-MM register file.
// Optional macro P_SIGNAL_SEQ_IRQ_EN adds the irq output and CTRL bit4 IRQ_ENABLE.
//
// state   | meaning
// IDLE    | out_port low, waiting for START
// ACTIVE  | out_port drives PATTERN (optionally blinking) for DURATION cycles
// HOLDOFF | out_port forced low for HOLDOFF_CYC cycles, DONE set on exit
module p_signal_sequencer #(
    parameter int CNT_W       = 24,
    parameter int HOLDOFF_CYC = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    p_signal_sequencer_if.slave  bus,
`ifdef P_SIGNAL_SEQ_IRQ_EN
    output logic                 irq,
`endif
    output logic [1:0]           out_port
);

    localparam int HW = $clog2(HOLDOFF_CYC + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [1:0]        pattern_q;
    logic [CNT_W-1:0]  duration_q;
    logic [CNT_W-1:0]  blink_q;
    logic [CNT_W-1:0]  blink_cap;
    logic [CNT_W-1:0]  dur_cnt;
    logic [CNT_W-1:0]  blink_cnt;
    logic [HW-1:0]     hold_cnt;
    logic              blink_on;
    logic              done_q;
    logic [1:0]        out_q;

    logic wr_en, ctrl_wr, start, abort;
    logic accept, go_active, enter_hold, hold_end, set_done, clr_done, busy;
    logic unused_wdata;

    assign wr_en   = bus.chipselect && !bus.write_n;
    assign ctrl_wr = wr_en && (bus.address == 2'd0);
    assign start   = ctrl_wr && bus.writedata[0];
    assign abort   = ctrl_wr && bus.writedata[1];
    assign unused_wdata = ^bus.writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        go_active  = 1'b0;
        enter_hold = 1'b0;
        hold_end   = 1'b0;
        case (state)
            IDLE: begin
                // ABORT in the same write suppresses the START
                if (start && !abort) begin
                    accept = 1'b1;
                    if (duration_q != '0) begin
                        go_active = 1'b1;
                        state_nxt = ACTIVE;
                    end
                end
            end
            ACTIVE: begin
                if (abort || dur_cnt <= CNT_W'(1)) begin
                    enter_hold = 1'b1;
                    state_nxt  = HOLDOFF;
                end
            end
            HOLDOFF: begin
                if (hold_cnt <= HW'(1)) begin
                    hold_end  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy     = (state == ACTIVE) || (state == HOLDOFF);
    assign set_done = hold_end || (accept && duration_q == '0);
    assign clr_done = wr_en && (bus.address == 2'd3) && bus.writedata[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            duration_q <= '0;
            blink_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            if (wr_en && bus.address == 2'd1) duration_q <= bus.writedata[CNT_W-1:0];
            if (wr_en && bus.address == 2'd2) blink_q    <= bus.writedata[CNT_W-1:0];
            if (set_done)      done_q <= 1'b1;
            else if (clr_done) done_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pattern_q <= 2'b00;
            dur_cnt   <= '0;
            blink_cnt <= '0;
            blink_cap <= '0;
            blink_on  <= 1'b0;
            hold_cnt  <= '0;
            out_q     <= 2'b00;
        end else begin
            if (accept) pattern_q <= bus.writedata[3:2];
            if (go_active) begin
                dur_cnt   <= duration_q;
                blink_cap <= blink_q;
                blink_cnt <= blink_q;
                blink_on  <= 1'b1;
                out_q     <= bus.writedata[3:2];
            end else if (enter_hold) begin
                dur_cnt   <= '0;
                blink_cnt <= '0;
                hold_cnt  <= HW'(HOLDOFF_CYC);
                out_q     <= 2'b00;
            end else if (state == ACTIVE) begin
                dur_cnt <= dur_cnt - CNT_W'(1);
                if (blink_cap != '0) begin
                    if (blink_cnt <= CNT_W'(1)) begin
                        blink_cnt <= blink_cap;
                        blink_on  <= !blink_on;
                        out_q     <= blink_on ? 2'b00 : pattern_q;
                    end else begin
                        blink_cnt <= blink_cnt - CNT_W'(1);
                    end
                end
            end else if (state == HOLDOFF) begin
                hold_cnt <= hold_cnt - HW'(1);
                out_q    <= 2'b00;
            end else begin
                hold_cnt <= '0;
                out_q    <= 2'b00;
            end
        end
    end

    assign out_port = out_q;

`ifdef P_SIGNAL_SEQ_IRQ_EN
    logic irq_en_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     irq_en_q <= 1'b0;
        else if (ctrl_wr) irq_en_q <= bus.writedata[4];
    end

    assign irq = done_q && irq_en_q;
`endif

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            2'd0: begin
                bus.readdata[3:2] = pattern_q;
`ifdef P_SIGNAL_SEQ_IRQ_EN
                bus.readdata[4] = irq_en_q;
`endif
            end
            2'd1: bus.readdata[CNT_W-1:0] = duration_q;
            2'd2: bus.readdata[CNT_W-1:0] = blink_q;
            default: begin
                bus.readdata[0]   = busy;
                bus.readdata[1]   = done_q;
                bus.readdata[5:4] = state;
            end
        endcase
    end

endmodule

// File: tb/tb_p_signal_sequencer.sv
// Directed self-checking bench for p_signal_sequencer: register table plus timed sequence checks.
module tb_p_signal_sequencer;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [1:0] out_port;
`ifdef P_SIGNAL_SEQ_IRQ_EN
    logic irq;
`endif

    p_signal_sequencer_if bus ();

    p_signal_sequencer #(.CNT_W(24), .HOLDOFF_CYC(16)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus.slave),
`ifdef P_SIGNAL_SEQ_IRQ_EN
        .irq      (irq),
`endif
        .out_port (out_port)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic        do_wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic do_read(input logic [1:0] a, output logic [31:0] d);
        bus.address = a;
        #1;
        d = bus.readdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [1:0]  blink_exp [8];
        bit          idle_seen;

        bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;

        tbl[0] = '{1'b0, 2'd3, 32'h0,        32'h0};
        tbl[1] = '{1'b1, 2'd1, 32'h123456,   32'h123456};
        tbl[2] = '{1'b1, 2'd1, 32'hFFFFFFFF, 32'h00FFFFFF};
        tbl[3] = '{1'b1, 2'd2, 32'hABCDEF,   32'hABCDEF};
        tbl[4] = '{1'b1, 2'd2, 32'h0,        32'h0};
        tbl[5] = '{1'b1, 2'd0, 32'hC,        32'h0};
`ifdef P_SIGNAL_SEQ_IRQ_EN
        tbl[6] = '{1'b1, 2'd0, 32'h10,       32'h10};
`else
        tbl[6] = '{1'b1, 2'd0, 32'h10,       32'h0};
`endif
        tbl[7] = '{1'b1, 2'd0, 32'h0,        32'h0};
        tbl[8] = '{1'b1, 2'd3, 32'h33,       32'h0};
        tbl[9] = '{1'b0, 2'd1, 32'h0,        32'h00FFFFFF};

        blink_exp[0] = 2'd3; blink_exp[1] = 2'd3; blink_exp[2] = 2'd0; blink_exp[3] = 2'd0;
        blink_exp[4] = 2'd3; blink_exp[5] = 2'd3; blink_exp[6] = 2'd0; blink_exp[7] = 2'd0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset out_port", {30'b0, out_port}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        do_read(2'd3, rd); chk("reset status", rd, 32'h0);
`ifdef P_SIGNAL_SEQ_IRQ_EN
        chk("reset irq", {31'b0, irq}, 32'h0);
`endif

        for (int i = 0; i < 10; i++) begin
            if (tbl[i].do_wr) do_write(tbl[i].addr, tbl[i].wdata);
            do_read(tbl[i].addr, rd);
            chk($sformatf("reg vec %0d", i), rd, tbl[i].exp);
        end

        // steady activation, pattern 2
        do_write(2'd1, 32'd5);
        do_write(2'd2, 32'd0);
        do_write(2'd0, 32'h9);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("steady out %0d", i), {30'b0, out_port}, 32'd2);
            do_read(2'd3, rd); chk($sformatf("steady status %0d", i), rd, 32'h11);
            tick();
        end
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("holdoff out %0d", i), {30'b0, out_port}, 32'd0);
            do_read(2'd3, rd); chk($sformatf("holdoff status %0d", i), rd, 32'h21);
            tick();
        end
        do_read(2'd3, rd); chk("steady done", rd, 32'h02);
        do_write(2'd3, 32'h2);
        do_read(2'd3, rd); chk("done clear", rd, 32'h0);

        // blinking, BLINK rewritten mid-activation must not disturb it
        do_write(2'd1, 32'd8);
        do_write(2'd2, 32'd2);
        do_write(2'd0, 32'hD);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("blink out %0d", i), {30'b0, out_port}, {30'b0, blink_exp[i]});
            do_read(2'd3, rd); chk($sformatf("blink status %0d", i), rd, 32'h11);
            if (i == 3) do_write(2'd2, 32'd7);
            else        tick();
        end
        chk("blink to holdoff out", {30'b0, out_port}, 32'd0);
        do_read(2'd3, rd); chk("blink to holdoff", rd, 32'h21);
        idle_seen = 1'b0;
        for (int i = 0; i < 40 && !idle_seen; i++) begin
            tick();
            do_read(2'd3, rd);
            if (rd[5:4] == 2'd0) idle_seen = 1'b1;
        end
        chk("blink done", rd, 32'h02);
        do_write(2'd3, 32'h2);

        // abort at ACTIVE cycle 2, START ignored in HOLDOFF, set beats clear
        do_write(2'd1, 32'd100);
        do_write(2'd0, 32'h5);
        chk("abort c1 out", {30'b0, out_port}, 32'd1);
        tick();
        chk("abort c2 out", {30'b0, out_port}, 32'd1);
        do_write(2'd0, 32'h2);
        chk("abort out", {30'b0, out_port}, 32'd0);
        do_read(2'd3, rd); chk("abort status", rd, 32'h21);
        do_write(2'd0, 32'hD);
        do_read(2'd3, rd); chk("start in holdoff status", rd, 32'h21);
        do_read(2'd0, rd); chk("start in holdoff pattern", rd, 32'h4);
        for (int i = 0; i < 14; i++) begin
            tick();
            do_read(2'd3, rd); chk($sformatf("abort holdoff %0d", i), rd, 32'h21);
        end
        do_write(2'd3, 32'h2);
        do_read(2'd3, rd); chk("done set beats clear", rd, 32'h02);
        do_write(2'd3, 32'h2);
        do_read(2'd3, rd); chk("abort done clear", rd, 32'h0);

        // zero duration
        do_write(2'd1, 32'd0);
        do_write(2'd0, 32'h1);
        chk("zero dur out", {30'b0, out_port}, 32'd0);
        do_read(2'd3, rd); chk("zero dur status", rd, 32'h02);
        do_write(2'd3, 32'h2);
        do_read(2'd3, rd); chk("zero dur clear", rd, 32'h0);

        // reset in the middle of ACTIVE
        do_write(2'd1, 32'd50);
        do_write(2'd0, 32'h5);
        tick();
        tick();
        chk("pre reset out", {30'b0, out_port}, 32'd1);
        #1 reset_n = 1'b0;
        #1 chk("async reset out", {30'b0, out_port}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        do_read(2'd3, rd); chk("post reset status", rd, 32'h0);
        do_read(2'd1, rd); chk("post reset duration", rd, 32'h0);
        do_read(2'd0, rd); chk("post reset pattern", rd, 32'h0);

`ifdef P_SIGNAL_SEQ_IRQ_EN
        do_write(2'd0, 32'h10);
        do_read(2'd0, rd); chk("irq enable readback", rd, 32'h10);
        chk("irq low before done", {31'b0, irq}, 32'h0);
        do_write(2'd0, 32'h11);
        chk("irq with done", {31'b0, irq}, 32'h1);
        do_write(2'd3, 32'h2);
        chk("irq after clear", {31'b0, irq}, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
